nios_debug_cmd_sync: RTL and testbench

System-clock-side command capture and decode for the Nios II JTAG debug slave, generalised in IR width, data-register width and synchroniser depth. Sits between the TCK-domain shift logic and the CPU OCI/break/trace units. It synchronises the virtual-JTAG update strobes into clk and latches the shift register into jdo. It then issues one take_action or take_no_action strobe per IR-selected channel.

---
 rtl/nios_debug_cmd_sync.sv | 141 ++++++++++++++
 tb/tb_nios_debug_cmd_sync.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_debug_cmd_sync.sv
// rtl/nios_debug_cmd_sync.sv - clk-side capture and per-channel decode of Nios II JTAG debug commands (option macro: DBG_CMD_ACK_EN)
module nios_debug_cmd_sync #(
   parameter int IR_W       = 2,
   parameter int DR_W       = 38,
   parameter int ACT_BIT    = 35,
   parameter int SYNC_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DR_W-1:0]       sr,
   input  logic [IR_W-1:0]       ir_in,
   input  logic                  vs_udr,
   input  logic                  vs_uir,
   input  logic                  cmd_ack,
   input  logic                  ovr_clr,
   output logic [DR_W-1:0]       jdo,
   output logic [IR_W-1:0]       ir_q,
   output logic [(1<<IR_W)-1:0]  take_action,
   output logic [(1<<IR_W)-1:0]  take_no_action,
   output logic                  busy,
   output logic                  overrun,
   output logic [7:0]            ovr_cnt
);
   localparam int CH    = 1 << IR_W;
   localparam int ARM_W = 3;
   localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT_ACK} state_t;

   state_t                state_q, state_d;
   logic [SYNC_DEPTH-1:0] udr_sync_q, udr_sync_d;
   logic [SYNC_DEPTH-1:0] uir_sync_q, uir_sync_d;
   logic                  udr_prev_q, udr_prev_d;
   logic                  uir_prev_q, uir_prev_d;
   logic [ARM_W-1:0]      arm_q, arm_d;
   logic [DR_W-1:0]       jdo_q, jdo_d;
   logic [IR_W-1:0]       ir_d;
   logic [CH-1:0]         act_q, act_d;
   logic [CH-1:0]         noact_q, noact_d;
   logic                  overrun_q, overrun_d;
   logic [7:0]            ovr_cnt_q, ovr_cnt_d;

   logic                  armed;
   logic                  udr_evt, uir_evt;
   logic                  accept, drop;
   logic [CH-1:0]         sel;

   // Synchroniser chains, edge detectors and the post-reset arm counter
   always_comb begin
      udr_sync_d = {udr_sync_q[SYNC_DEPTH-2:0], vs_udr};
      uir_sync_d = {uir_sync_q[SYNC_DEPTH-2:0], vs_uir};
      udr_prev_d = udr_sync_q[SYNC_DEPTH-1];
      uir_prev_d = uir_sync_q[SYNC_DEPTH-1];
      armed      = (arm_q == ARM_MAX);
      arm_d      = armed ? arm_q : arm_q + ARM_W'(1);
      // Edges that arrive while the chains are still filling (e.g. a level held through reset) are ignored
      udr_evt    = armed & udr_sync_q[SYNC_DEPTH-1] & ~udr_prev_q;
      uir_evt    = armed & uir_sync_q[SYNC_DEPTH-1] & ~uir_prev_q;
   end

   // Next-state logic of the command FSM
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (udr_evt) state_d = S_STROBE;
`ifdef DBG_CMD_ACK_EN
         S_STROBE:   state_d = cmd_ack ? S_IDLE : S_WAIT_ACK;
`else
         S_STROBE:   state_d = S_IDLE;
`endif
         S_WAIT_ACK: if (cmd_ack) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs: data latch, strobes, IR and overrun bookkeeping
   always_comb begin
      accept  = udr_evt & (state_q == S_IDLE);
      drop    = udr_evt & (state_q != S_IDLE);
      sel     = CH'(1) << ir_q;
      jdo_d   = accept ? sr : jdo_q;
      // ir_q updates on the same edge the command is accepted, so the decode always sees the old IR
      ir_d    = uir_evt ? ir_in : ir_q;
      act_d   = act_q;
      noact_d = noact_q;
      if (accept) begin
         act_d   = sr[ACT_BIT] ? sel : '0;
         noact_d = sr[ACT_BIT] ? '0 : sel;
      end else if (state_d == S_IDLE) begin
         act_d   = '0;
         noact_d = '0;
      end
      overrun_d = overrun_q;
      ovr_cnt_d = ovr_cnt_q;
      if (ovr_clr) begin
         overrun_d = 1'b0;
         ovr_cnt_d = 8'd0;
      end else if (drop) begin
         overrun_d = 1'b1;
         ovr_cnt_d = (ovr_cnt_q == 8'hFF) ? ovr_cnt_q : ovr_cnt_q + 8'd1;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         udr_sync_q <= '0;
         uir_sync_q <= '0;
         udr_prev_q <= 1'b0;
         uir_prev_q <= 1'b0;
         arm_q      <= '0;
         jdo_q      <= '0;
         ir_q       <= '0;
         act_q      <= '0;
         noact_q    <= '0;
         overrun_q  <= 1'b0;
         ovr_cnt_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         udr_sync_q <= udr_sync_d;
         uir_sync_q <= uir_sync_d;
         udr_prev_q <= udr_prev_d;
         uir_prev_q <= uir_prev_d;
         arm_q      <= arm_d;
         jdo_q      <= jdo_d;
         ir_q       <= ir_d;
         act_q      <= act_d;
         noact_q    <= noact_d;
         overrun_q  <= overrun_d;
         ovr_cnt_q  <= ovr_cnt_d;
      end
   end

   assign jdo            = jdo_q;
   assign take_action    = act_q;
   assign take_no_action = noact_q;
   assign busy           = (state_q != S_IDLE);
   assign overrun        = overrun_q;
   assign ovr_cnt        = ovr_cnt_q;
endmodule

// File: tb/tb_nios_debug_cmd_sync.sv
// tb/tb_nios_debug_cmd_sync.sv - randomized self-checking bench for nios_debug_cmd_sync (option macro: DBG_CMD_ACK_EN)
module tb_nios_debug_cmd_sync;
   localparam int IR_W       = 2;
   localparam int DR_W       = 38;
   localparam int ACT_BIT    = 35;
   localparam int SYNC_DEPTH = 2;
   localparam int CH         = 1 << IR_W;
   // Input raised at a falling edge: SYNC_DEPTH rising edges fill the chain, one more registers the command
   localparam int LAT        = SYNC_DEPTH + 1;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [DR_W-1:0]   sr;
   logic [IR_W-1:0]   ir_in;
   logic              vs_udr, vs_uir, cmd_ack, ovr_clr;
   logic [DR_W-1:0]   jdo;
   logic [IR_W-1:0]   ir_q;
   logic [CH-1:0]     take_action, take_no_action;
   logic              busy, overrun;
   logic [7:0]        ovr_cnt;

   int total = 0;
   int bad   = 0;
   logic [IR_W-1:0]   model_ir;

   nios_debug_cmd_sync #(
      .IR_W(IR_W), .DR_W(DR_W), .ACT_BIT(ACT_BIT), .SYNC_DEPTH(SYNC_DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
      .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ack(cmd_ack), .ovr_clr(ovr_clr),
      .jdo(jdo), .ir_q(ir_q), .take_action(take_action), .take_no_action(take_no_action),
      .busy(busy), .overrun(overrun), .ovr_cnt(ovr_cnt)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      logic [DR_W-1:0] v;
      int strobes;
      v = {6'($urandom()), 32'($urandom())};
      v[ACT_BIT] = 1'b1;
      reset_n = 1'b0; sr = v; ir_in = 2'd3; vs_udr = 1'b1; vs_uir = 1'b0; ovr_clr = 1'b0;
`ifdef DBG_CMD_ACK_EN
      cmd_ack = 1'b1;
`else
      cmd_ack = 1'b0;
`endif
      repeat (3) @(negedge clk);
      total++;
      if ({jdo, ir_q, take_action, take_no_action, busy, overrun, ovr_cnt} !== '0) begin
         bad++; $display("FAIL reset_outputs: got jdo=%h ir=%h act=%b noact=%b busy=%b ovr=%b cnt=%0d want all 0",
                         jdo, ir_q, take_action, take_no_action, busy, overrun, ovr_cnt);
      end
      reset_n = 1'b1;
      model_ir = '0;
      strobes = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if ((take_action | take_no_action) != '0 || busy) strobes++;
      end
      total++;
      if (strobes !== 0) begin bad++; $display("FAIL held_udr_no_strobe: got %0d strobe cycles want 0", strobes); end
      total++;
      if (jdo !== '0) begin bad++; $display("FAIL held_udr_jdo: got %h want 0", jdo); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL held_udr_busy: got %b want 0", busy); end
      vs_udr = 1'b0;
      repeat (LAT + 2) @(negedge clk);
   endtask

   task automatic load_ir(input logic [IR_W-1:0] v);
      @(negedge clk);
      ir_in = v; vs_uir = 1'b1;
      repeat (LAT + 1) @(negedge clk);
      vs_uir = 1'b0;
      repeat (LAT + 1) @(negedge clk);
      model_ir = v;
      total++;
      if (ir_q !== model_ir) begin bad++; $display("FAIL load_ir: got %h want %h", ir_q, model_ir); end
   endtask

   task automatic run_cmd(input logic [DR_W-1:0] v, input bit with_uir, input logic [IR_W-1:0] new_ir);
      logic [CH-1:0]   exp_act, exp_noact, seen_act, seen_noact;
      logic [DR_W-1:0] seen_jdo;
      int first_k, width, busy_width;
      exp_act   = v[ACT_BIT] ? (CH'(1) << model_ir) : '0;
      exp_noact = v[ACT_BIT] ? '0 : (CH'(1) << model_ir);
      first_k = -1; width = 0; busy_width = 0;
      seen_act = '0; seen_noact = '0; seen_jdo = '0;
      @(negedge clk);
      sr = v; vs_udr = 1'b1;
      if (with_uir) begin ir_in = new_ir; vs_uir = 1'b1; end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 5) begin vs_udr = 1'b0; vs_uir = 1'b0; end
         if ((take_action | take_no_action) != '0) begin
            if (first_k < 0) begin
               first_k = k; seen_act = take_action; seen_noact = take_no_action; seen_jdo = jdo;
            end
            width++;
         end
         if (busy) busy_width++;
      end
      if (with_uir) model_ir = new_ir;
      total++;
      if (first_k !== LAT) begin bad++; $display("FAIL cmd_latency: got %0d want %0d", first_k, LAT); end
      total++;
      if (seen_act !== exp_act) begin bad++; $display("FAIL cmd_take_action: got %b want %b", seen_act, exp_act); end
      total++;
      if (seen_noact !== exp_noact) begin bad++; $display("FAIL cmd_take_no_action: got %b want %b", seen_noact, exp_noact); end
      total++;
      if (seen_jdo !== v) begin bad++; $display("FAIL cmd_jdo_at_strobe: got %h want %h", seen_jdo, v); end
      total++;
      if (width !== 1) begin bad++; $display("FAIL cmd_strobe_width: got %0d want 1", width); end
      total++;
      if (busy_width !== 1) begin bad++; $display("FAIL cmd_busy_width: got %0d want 1", busy_width); end
      total++;
      if (jdo !== v) begin bad++; $display("FAIL cmd_jdo_hold: got %h want %h", jdo, v); end
      total++;
      if (overrun !== 1'b0 || ovr_cnt !== 8'd0) begin
         bad++; $display("FAIL cmd_no_overrun: got ovr=%b cnt=%0d want 0/0", overrun, ovr_cnt);
      end
      total++;
      if (ir_q !== model_ir) begin bad++; $display("FAIL cmd_ir_q: got %h want %h", ir_q, model_ir); end
   endtask

   task automatic test_action();
      load_ir(2'b01);
      run_cmd(38'h8_1234_5678, 1'b0, '0);
   endtask

   task automatic test_no_action();
      load_ir(2'b11);
      run_cmd(38'h2_1234_5678, 1'b0, '0);
   endtask

   task automatic test_simultaneous();
      logic [DR_W-1:0] v;
      load_ir(2'd0);
      v = {6'($urandom()), 32'($urandom())};
      v[ACT_BIT] = 1'b1;
      run_cmd(v, 1'b1, 2'd2);
   endtask

   task automatic test_random();
      logic [DR_W-1:0] v;
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(1, 0) == 1) load_ir(IR_W'($urandom()));
         v = {6'($urandom()), 32'($urandom())};
         run_cmd(v, bit'($urandom_range(1, 0)), IR_W'($urandom()));
      end
   endtask

   task automatic test_back_to_back();
      logic [DR_W-1:0] v;
      logic [CH-1:0]   exp_act, exp_noact;
      int strobes, good;
      v = {6'($urandom()), 32'($urandom())};
      exp_act   = v[ACT_BIT] ? (CH'(1) << model_ir) : '0;
      exp_noact = v[ACT_BIT] ? '0 : (CH'(1) << model_ir);
      strobes = 0; good = 0;
      @(negedge clk);
      sr = v;
      for (int k = 0; k < 24; k++) begin
         vs_udr = ((k % 4) < 2) && (k < 12);
         @(negedge clk);
         if ((take_action | take_no_action) != '0) begin
            strobes++;
            if (take_action === exp_act && take_no_action === exp_noact) good++;
         end
      end
      total++;
      if (strobes !== 3) begin bad++; $display("FAIL b2b_strobe_count: got %0d want 3", strobes); end
      total++;
      if (good !== 3) begin bad++; $display("FAIL b2b_strobe_value: got %0d correct want 3", good); end
      total++;
      if (overrun !== 1'b0 || ovr_cnt !== 8'd0) begin
         bad++; $display("FAIL b2b_no_overrun: got ovr=%b cnt=%0d want 0/0", overrun, ovr_cnt);
      end
      total++;
      if (jdo !== v) begin bad++; $display("FAIL b2b_jdo: got %h want %h", jdo, v); end
   endtask

`ifdef DBG_CMD_ACK_EN
   task automatic udr_pulse(input logic [DR_W-1:0] v, input int hi, input int lo);
      @(negedge clk);
      sr = v; vs_udr = 1'b1;
      repeat (hi) @(negedge clk);
      vs_udr = 1'b0;
      repeat (lo - 1) @(negedge clk);
   endtask

   task automatic test_ack_hold();
      logic [DR_W-1:0] v1;
      logic [CH-1:0]   exp_act;
      v1 = {6'($urandom()), 32'($urandom())};
      v1[ACT_BIT] = 1'b1;
      exp_act = CH'(1) << model_ir;
      cmd_ack = 1'b0;
      udr_pulse(v1, 3, 3);
      for (int i = 0; i < 3; i++) udr_pulse({6'($urandom()), 32'($urandom())}, 2, 3);
      repeat (2) @(negedge clk);
      total++;
      if (take_action !== exp_act || take_no_action !== '0) begin
         bad++; $display("FAIL ack_strobe_held: got act=%b noact=%b want act=%b noact=0", take_action, take_no_action, exp_act);
      end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL ack_busy: got %b want 1", busy); end
      total++;
      if (overrun !== 1'b1 || ovr_cnt !== 8'd3) begin
         bad++; $display("FAIL ack_overrun: got ovr=%b cnt=%0d want 1/3", overrun, ovr_cnt);
      end
      total++;
      if (jdo !== v1) begin bad++; $display("FAIL ack_jdo_kept: got %h want %h", jdo, v1); end
      cmd_ack = 1'b1;
      @(negedge clk);
      total++;
      if ((take_action | take_no_action) !== '0 || busy !== 1'b0) begin
         bad++; $display("FAIL ack_release: got act=%b noact=%b busy=%b want 0", take_action, take_no_action, busy);
      end
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      total++;
      if (overrun !== 1'b0 || ovr_cnt !== 8'd0) begin
         bad++; $display("FAIL ack_ovr_clr: got ovr=%b cnt=%0d want 0/0", overrun, ovr_cnt);
      end
   endtask

   task automatic test_saturate();
      logic [DR_W-1:0] v1;
      v1 = {6'($urandom()), 32'($urandom())};
      cmd_ack = 1'b0;
      udr_pulse(v1, 3, 3);
      for (int i = 0; i < 260; i++) udr_pulse({6'($urandom()), 32'($urandom())}, 2, 2);
      repeat (4) @(negedge clk);
      total++;
      if (ovr_cnt !== 8'd255 || overrun !== 1'b1) begin
         bad++; $display("FAIL sat_ovr_cnt: got ovr=%b cnt=%0d want 1/255", overrun, ovr_cnt);
      end
      total++;
      if (jdo !== v1 || busy !== 1'b1) begin
         bad++; $display("FAIL sat_jdo_busy: got jdo=%h busy=%b want jdo=%h busy=1", jdo, busy, v1);
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({jdo, ir_q, take_action, take_no_action, busy, overrun, ovr_cnt} !== '0) begin
         bad++; $display("FAIL sat_async_reset: got jdo=%h ir=%h act=%b noact=%b busy=%b ovr=%b cnt=%0d want all 0",
                         jdo, ir_q, take_action, take_no_action, busy, overrun, ovr_cnt);
      end
      @(negedge clk);
      reset_n = 1'b1;
      cmd_ack = 1'b1;
      model_ir = '0;
      repeat (LAT + 2) @(negedge clk);
   endtask
`endif

   task automatic test_async_reset();
      logic [DR_W-1:0] v;
      load_ir(2'd3);
      v = {6'($urandom()), 32'($urandom())};
      @(negedge clk);
      sr = v; vs_udr = 1'b1;
      repeat (LAT) @(negedge clk);
      total++;
      if ((take_action | take_no_action) === '0) begin
         bad++; $display("FAIL rst_strobe_before: got act=%b noact=%b want a strobe", take_action, take_no_action);
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({jdo, ir_q, take_action, take_no_action, busy, overrun, ovr_cnt} !== '0) begin
         bad++; $display("FAIL rst_async_clear: got jdo=%h ir=%h act=%b noact=%b busy=%b ovr=%b cnt=%0d want all 0",
                         jdo, ir_q, take_action, take_no_action, busy, overrun, ovr_cnt);
      end
      vs_udr = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      model_ir = '0;
      repeat (LAT + 2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_action();
      test_no_action();
      test_simultaneous();
      test_random();
      test_back_to_back();
`ifdef DBG_CMD_ACK_EN
      test_ack_hold();
      test_saturate();
`endif
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
